// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator's serial sign conversion blocks.
package calc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Widest word the saturation pattern below covers.
  localparam int unsigned MaxN = 64;

  // Most-negative input has no sign-magnitude form; it saturates to {1, all ones}.
  localparam logic [MaxN-1:0] SatPattern = {1'b1, {(MaxN-1){1'b1}}};

  // Bit-counter width; a 1-bit counter still suffices for the N = 2 corner.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/twos_to_sign_mag_serial_if.sv
// Valid/ready input and output channels of the serial sign converter.
interface twos_to_sign_mag_serial_if #(
  parameter int unsigned N = 8
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_ovf;

  // Producer/consumer side driving the converter.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // Converter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/serial_negate_cell.sv
// One bit of serial two's-complement negation: copy bits up to and including
// the first one, invert every bit after it. Passes bits through when sign is 0.
module serial_negate_cell (
  input  logic b_i,
  input  logic sign_i,
  input  logic seen_one_i,
  output logic res_o,
  output logic seen_one_o
);

  // Per-bit result and updated first-one tracker.
  always_comb begin
    res_o      = (sign_i && seen_one_i) ? ~b_i : b_i;
    seen_one_o = sign_i ? (seen_one_i | b_i) : seen_one_i;
  end

endmodule

// File: rtl/twos_to_sign_mag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first, one bit
// per clock, with valid/ready handshakes on both sides.
module twos_to_sign_mag_serial
  import calc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  twos_to_sign_mag_serial_if.slave  bus,
  output logic                      busy
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic [N-1:0]    shreg_q, shreg_d;
  logic            sign_q, sign_d;
  logic            seen_q, seen_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-2:0]    mag_q, mag_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic            out_ovf_q, out_ovf_d;

  logic            res_bit;
  logic            seen_next;
  logic            ovf;
  logic [N-1:0]    mag_ext;

  serial_negate_cell u_cell (
    .b_i        (shreg_q[0]),
    .sign_i     (sign_q),
    .seen_one_i (seen_q),
    .res_o      (res_bit),
    .seen_one_o (seen_next)
  );

  // Next-state logic: accept in IDLE, shift N-1 bits, hold the result in DONE.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    sign_d     = sign_q;
    seen_d     = seen_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    // New result bit enters at the top of the magnitude; works down to N = 2.
    mag_ext    = {res_bit, mag_q} >> 1;
    // No one among the low bits of a negative word means it was 100..0.
    ovf        = sign_q & ~seen_next;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          sign_d  = bus.in_data[N-1];
          seen_d  = 1'b0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = shreg_q >> 1;
        mag_d   = mag_ext[N-2:0];
        seen_d  = seen_next;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 2)) begin
          out_data_d = ovf ? SatPattern[N-1:0] : {sign_q, mag_ext[N-2:0]};
          out_ovf_d  = ovf;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state only; in_ready stays low during reset.
  always_comb begin
    bus.in_ready  = (state_q == StIdle) && !rst;
    bus.out_valid = (state_q == StDone);
    bus.out_data  = out_data_q;
    bus.out_ovf   = out_ovf_q;
    busy          = (state_q == StShift);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      sign_q     <= 1'b0;
      seen_q     <= 1'b0;
      cnt_q      <= '0;
      mag_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      sign_q     <= sign_d;
      seen_q     <= seen_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_twos_to_sign_mag_serial.sv
// Directed bench for the serial two's-complement to sign-magnitude converter.
module tb_twos_to_sign_mag_serial;

  localparam int unsigned N = 8;

  logic clk;
  logic rst;
  logic busy;

  int unsigned n_tests;
  int unsigned n_fail;

  twos_to_sign_mag_serial_if #(.N(N)) bus ();

  twos_to_sign_mag_serial #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: {ovf, sign-magnitude word}.
  function automatic logic [8:0] ref_conv(input logic [7:0] x);
    logic [7:0] neg;
    if (x == 8'h80) return {1'b1, 8'hFF};
    if (!x[7]) return {1'b0, x};
    neg = ~x + 8'd1;
    return {1'b0, 1'b1, neg[6:0]};
  endfunction

  // One word through with out_ready high; checks latency, result, return to IDLE.
  task automatic convert(input string tag, input logic [7:0] din,
                         input logic [7:0] exp_d, input logic exp_o);
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = din;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~din;
    // Cycle 1 is the first SHIFT cycle after the accepting edge.
    n = 1;
    while (!bus.out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_data"}, 32'(bus.out_data), 32'(exp_d));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_o));
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int n;
    int got;
    logic [8:0] exp9;

    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(bus.in_ready), 32'd1);

    // Directed conversions.
    convert("pos5", 8'h05, 8'h05, 1'b0);
    convert("neg5", 8'hFB, 8'h85, 1'b0);
    convert("neg127", 8'h81, 8'hFF, 1'b0);
    convert("neg128", 8'h80, 8'hFF, 1'b1);
    convert("zero", 8'h00, 8'h00, 1'b0);
    convert("pos127", 8'h7F, 8'h7F, 1'b0);

    // Backpressure: result held, input traffic ignored.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h3C;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 32'(bus.out_data), 32'h3C);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = ~bus.in_valid;
      bus.in_data  = 8'h80 + 8'(i);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_release_data", 32'(bus.out_data), 32'h3C);
    @(posedge clk); #1;
    check("bp_after_ready", 32'(bus.in_ready), 32'd1);
    check("bp_after_valid", 32'(bus.out_valid), 32'd0);
    convert("neg60", 8'hC4, 8'hBC, 1'b0);

    // Reset during SHIFT abandons the word.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_release_ready", 32'(bus.in_ready), 32'd1);
    convert("negF0", 8'hF0, 8'h90, 1'b0);

    // Back-to-back sweep of every input with random output backpressure.
    bus.out_ready = 1'b0;
    fork
      begin
        int w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
          bus.in_data = 8'(i);
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (!bus.in_ready && w < 100);
          if (!bus.in_ready) begin
            check("b2b_accept", 32'(bus.in_ready), 32'd1);
            break;
          end
          @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
      end
      begin
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 256 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid && bus.out_ready) begin
            exp9 = ref_conv(8'(got));
            check("b2b_result", 32'({bus.out_ovf, bus.out_data}), 32'(exp9));
            got++;
          end
        end
        check("b2b_count", 32'(got), 32'd256);
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
